noc_input_buffer: RTL

- Per-port input buffer of the mesh router. It sits directly downstream of the link that delivers VC-tagged flits (flit_Data_withvc, 25 bits) from the neighbouring router or local injector.
- Demultiplexes incoming flits by vc_Id into one FIFO per virtual channel and stores them as flit_Data_noVC (24 bits).
- Presents each VC's front flit to the route/VC/switch-allocation stages.
- Returns one credit per dequeued flit to the upstream sender.
- Tracks per-VC packet state (IDLE/ACTIVE).

---
 rtl/noc_input_buffer_if.sv | 26 ++
 rtl/noc_input_buffer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/noc_input_buffer_if.sv
// Link-side bundle of the router input buffer: VC-tagged flits in, per-VC front flits and credits out.
interface noc_input_buffer_if #(
  parameter int VC_NUM  = 2,
  parameter int VC_SIZE = 1
);
  logic [VC_SIZE+23:0]     data_i;
  logic                    valid_i;
  logic                    read_i;
  logic [VC_SIZE-1:0]      read_vc_i;
  logic [VC_NUM-1:0][23:0] data_o;
  logic [VC_NUM-1:0]       valid_o;
  logic [VC_NUM-1:0]       head_o;
  logic [VC_NUM-1:0]       vc_active_o;
  logic [VC_NUM-1:0]       credit_o;
  logic [VC_NUM-1:0]       full_o;

  modport master (
    output data_i, valid_i, read_i, read_vc_i,
    input  data_o, valid_o, head_o, vc_active_o, credit_o, full_o
  );

  modport slave (
    input  data_i, valid_i, read_i, read_vc_i,
    output data_o, valid_o, head_o, vc_active_o, credit_o, full_o
  );
endinterface

// File: rtl/noc_input_buffer.sv
// Per-port router input buffer: one circular FIFO per VC, packet state tracking and credit return.
// Optional sticky error flags (err_o) are enabled by defining NOC_INPUT_BUFFER_ERR_EN.
package params_noc;
  localparam int vc_Num  = 2;
  localparam int VC_Size = 1;

  typedef enum logic [1:0] {
    HEAD     = 2'd0,
    BODY     = 2'd1,
    TAIL     = 2'd2,
    HEADTAIL = 2'd3
  } flit_label_t;

  typedef struct packed {
    flit_label_t flit_DataLabel;
    logic [2:0]  x_Dest;
    logic [2:0]  y_Dest;
    logic [15:0] data;
  } flit_Data_noVC;

  typedef struct packed {
    logic [VC_Size-1:0] vc_Id;
    flit_label_t        flit_DataLabel;
    logic [2:0]         x_Dest;
    logic [2:0]         y_Dest;
    logic [15:0]        data;
  } flit_Data_withvc;
endpackage

module noc_input_buffer
  import params_noc::*;
#(
  parameter int BUFFER_DEPTH = 4,
  parameter int VC_NUM       = vc_Num
) (
  input  logic              clk,
  input  logic              rst,
  noc_input_buffer_if.slave bus
`ifdef NOC_INPUT_BUFFER_ERR_EN
  ,
  output logic [2:0]        err_o
`endif
);
  localparam int PTR_W = $clog2(BUFFER_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} vc_state_t;

  function automatic vc_state_t next_state(input vc_state_t st, input flit_label_t lab);
    vc_state_t nxt;
    nxt = st;
    case ({st, lab})
      {IDLE,   HEAD}: nxt = ACTIVE;
      {ACTIVE, TAIL}: nxt = IDLE;
      default:        nxt = st;
    endcase
    return nxt;
  endfunction

  flit_Data_noVC     r_mem    [VC_NUM][BUFFER_DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr [VC_NUM];
  logic [PTR_W-1:0]  r_wr_ptr [VC_NUM];
  logic [CNT_W-1:0]  r_count  [VC_NUM];
  vc_state_t         r_state  [VC_NUM];
  logic [VC_NUM-1:0] r_credit;

  flit_Data_withvc   w_in;
  flit_Data_noVC     w_store;
  flit_Data_noVC     w_front  [VC_NUM];
  logic [VC_NUM-1:0] w_valid;
  logic [VC_NUM-1:0] w_full;
  logic [VC_NUM-1:0] w_rd_en;
  logic [VC_NUM-1:0] w_wr_en;

  assign w_in    = bus.data_i;
  assign w_store = {w_in.flit_DataLabel, w_in.x_Dest, w_in.y_Dest, w_in.data};

  // Occupancy flags, front flits and write/read qualification per VC.
  always_comb begin
    w_valid = {VC_NUM{1'b0}};
    w_full  = {VC_NUM{1'b0}};
    w_rd_en = {VC_NUM{1'b0}};
    w_wr_en = {VC_NUM{1'b0}};
    for (int v = 0; v < VC_NUM; v++) begin
      w_front[v] = r_mem[v][r_rd_ptr[v]];
      w_valid[v] = (r_count[v] != {CNT_W{1'b0}});
      w_full[v]  = (r_count[v] == CNT_W'(BUFFER_DEPTH));
      w_rd_en[v] = bus.read_i && (bus.read_vc_i == VC_Size'(v)) && w_valid[v];
      // A full VC still takes the write when its head is leaving in the same cycle.
      w_wr_en[v] = bus.valid_i && (w_in.vc_Id == VC_Size'(v)) && (!w_full[v] || w_rd_en[v]);
    end
  end

  // Output decode; data_o is forced to zero on an empty VC so stale storage never leaks.
  always_comb begin
    bus.data_o      = {VC_NUM{24'h0}};
    bus.valid_o     = w_valid;
    bus.full_o      = w_full;
    bus.credit_o    = r_credit;
    bus.head_o      = {VC_NUM{1'b0}};
    bus.vc_active_o = {VC_NUM{1'b0}};
    for (int v = 0; v < VC_NUM; v++) begin
      bus.data_o[v]      = w_valid[v] ? w_front[v] : 24'h0;
      bus.vc_active_o[v] = (r_state[v] == ACTIVE);
      bus.head_o[v]      = w_valid[v] && (r_state[v] == IDLE) &&
                           ((w_front[v].flit_DataLabel == HEAD) ||
                            (w_front[v].flit_DataLabel == HEADTAIL));
    end
  end

  // Flit storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    for (int v = 0; v < VC_NUM; v++) begin
      if (w_wr_en[v]) begin
        r_mem[v][r_wr_ptr[v]] <= w_store;
      end
    end
  end

  // Pointers, occupancy, packet state and the registered credit pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_credit <= {VC_NUM{1'b0}};
      for (int v = 0; v < VC_NUM; v++) begin
        r_rd_ptr[v] <= {PTR_W{1'b0}};
        r_wr_ptr[v] <= {PTR_W{1'b0}};
        r_count[v]  <= {CNT_W{1'b0}};
        r_state[v]  <= IDLE;
      end
    end else begin
      r_credit <= w_rd_en;
      for (int v = 0; v < VC_NUM; v++) begin
        if (w_wr_en[v]) begin
          r_wr_ptr[v] <= r_wr_ptr[v] + PTR_W'(1);
        end
        if (w_rd_en[v]) begin
          r_rd_ptr[v] <= r_rd_ptr[v] + PTR_W'(1);
          r_state[v]  <= next_state(r_state[v], w_front[v].flit_DataLabel);
        end
        case ({w_wr_en[v], w_rd_en[v]})
          2'b10:   r_count[v] <= r_count[v] + CNT_W'(1);
          2'b01:   r_count[v] <= r_count[v] - CNT_W'(1);
          default: r_count[v] <= r_count[v];
        endcase
      end
    end
  end

`ifdef NOC_INPUT_BUFFER_ERR_EN
  function automatic logic is_violation(input vc_state_t st, input flit_label_t lab);
    logic bad;
    case (st)
      IDLE:    bad = (lab == BODY) || (lab == TAIL);
      ACTIVE:  bad = (lab == HEAD) || (lab == HEADTAIL);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

  logic [2:0] r_err;
  logic [2:0] w_err_evt;

  // Overflow, underflow and protocol-violation events of the current cycle.
  always_comb begin
    w_err_evt    = 3'b000;
    w_err_evt[0] = bus.valid_i && w_full[w_in.vc_Id] && !w_rd_en[w_in.vc_Id];
    w_err_evt[1] = bus.read_i && !w_valid[bus.read_vc_i];
    for (int v = 0; v < VC_NUM; v++) begin
      if (w_rd_en[v] && is_violation(r_state[v], w_front[v].flit_DataLabel)) begin
        w_err_evt[2] = 1'b1;
      end else begin
        w_err_evt[2] = w_err_evt[2];
      end
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 3'b000;
    end else begin
      r_err <= r_err | w_err_evt;
    end
  end

  assign err_o = r_err;
`endif
endmodule
